hex_display_scanner: RTL and testbench

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment hex digits. It latches a multi-digit value and scans one digit at a time with a programmable dwell period. Features include a one-cycle anti-ghosting gap, optional leading-zero blanking, per-digit blink and decimal points. It sits between datapath status registers and the board display pins, replacing per-digit combinational decoders where pins are shared.

---
 rtl/hex_disp_pkg.sv | 19 +
 rtl/hex_seg_decode.sv | 11 +
 rtl/hex_display_scanner.sv | 137 +++++++++++++
 tb/tb_hex_display_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the seven-segment hex scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package hex_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        GAP,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-low seven-segment code.
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode hex display driver with anti-ghosting gap,
// leading-zero blanking, per-digit blink and decimal points.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [FRM_W-1:0]        frame_q;
    logic                    blink_q;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    scan_state_t             state_q;

    logic                  last_cnt;
    logic                  last_idx;
    logic                  frame_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  upper_zero;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_show;
    logic [6:0]            dec_seg;

    assign last_cnt  = (cnt_q == CNT_LAST);
    assign last_idx  = (idx_q == IDX_LAST);
    assign frame_end = last_cnt && last_idx;

    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        upper_zero = 1'b1;
        an_show    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_nib    = shadow_q[4*i +: 4];
                cur_dp     = dp_q[i];
                cur_blink  = blink_mask[i];
                an_show[i] = 1'b0;
            end
            // Leading-zero test covers the current digit and everything above it.
            if (IDX_W'(i) >= idx_q && shadow_q[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        blank = (lz_en && (idx_q != '0) && upper_zero) || (cur_blink && blink_q);
    end

    hex_seg_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            blink_q    <= 1'b0;
            shadow_q   <= '0;
            dp_q       <= '0;
            state_q    <= GAP;
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= value;
                dp_q     <= dp_in;
            end

            cnt_q <= last_cnt ? '0 : cnt_q + CNT_W'(1);
            if (last_cnt) begin
                idx_q <= last_idx ? '0 : idx_q + IDX_W'(1);
            end

            if (frame_end) begin
                if (frame_q == FRM_LAST) begin
                    frame_q <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    frame_q <= frame_q + FRM_W'(1);
                end
            end

            // GAP is exactly the cnt==0 cycle of every slot.
            state_q    <= last_cnt ? GAP : SHOW;
            frame_tick <= frame_end;

            unique case (state_q)
                GAP: begin
                    seg  <= SEG_BLANK;
                    dp_n <= 1'b1;
                    an   <= '1;
                end
                SHOW: begin
                    an   <= an_show;
                    seg  <= blank ? SEG_BLANK : dec_seg;
                    dp_n <= blank | ~cur_dp;
                end
                default: begin
                    seg  <= SEG_BLANK;
                    dp_n <= 1'b1;
                    an   <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (4 digits, 4-cycle slots, 2-frame blink).
module tb_hex_display_scanner;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_mask = '0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    hex_display_scanner #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_checks = 0;
    int n_err    = 0;
    int p        = 0;      // clock edges since reset release
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        int          digit;
        logic [6:0]  seg;
        logic        dp_n;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan position derived purely from elapsed edges since reset.
    task automatic tick(input string tag);
        int cnt, di, fr;
        bit ph;
        logic [6:0]  e_seg;
        logic        e_dpn;
        logic [3:0]  e_an;
        logic        e_ft;
        logic [15:0] upper;
        cnt   = p % SD;
        di    = (p / SD) % ND;
        fr    = p / (ND * SD);
        ph    = ((fr / BF) % 2) == 1;
        e_ft  = (cnt == SD - 1) && (di == ND - 1);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dpn = 1'b1;
        if (cnt != 0) begin
            e_an[di] = 1'b0;
            upper = m_val >> (4 * di);
            if (!((lz_en && di > 0 && upper == 16'h0) || (blink_mask[di] && ph))) begin
                e_seg = lut[upper[3:0]];
                e_dpn = ~m_dp[di];
            end
        end
        if (load) begin
            m_val = value;
            m_dp  = dp_in;
        end
        @(posedge clk);
        #1;
        p++;
        check({tag, "/seg"}, 32'(seg), 32'(e_seg));
        check({tag, "/dp_n"}, 32'(dp_n), 32'(e_dpn));
        check({tag, "/an"}, 32'(an), 32'(e_an));
        check({tag, "/frame_tick"}, 32'(frame_tick), 32'(e_ft));
    endtask

    task automatic do_reset();
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async/an", 32'(an), 32'hF);
        check("rst_async/seg", 32'(seg), 32'h7F);
        check("rst_async/dp_n", 32'(dp_n), 32'h1);
        check("rst_async/frame_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold/an", 32'(an), 32'hF);
        check("rst_hold/frame_tick", 32'(frame_tick), 32'h0);
        #2;
        rst   = 1'b0;
        p     = 0;
        m_val = '0;
        m_dp  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last_ft;
        int n_ft;

        vecs[0]  = '{16'h12AF, 4'b0100, 1'b0, 0, 7'h0E, 1'b1};
        vecs[1]  = '{16'h12AF, 4'b0100, 1'b0, 1, 7'h08, 1'b1};
        vecs[2]  = '{16'h12AF, 4'b0100, 1'b0, 2, 7'h24, 1'b0};
        vecs[3]  = '{16'h12AF, 4'b0100, 1'b0, 3, 7'h79, 1'b1};
        vecs[4]  = '{16'h0005, 4'b0000, 1'b1, 3, 7'h7F, 1'b1};
        vecs[5]  = '{16'h0005, 4'b0000, 1'b1, 1, 7'h7F, 1'b1};
        vecs[6]  = '{16'h0005, 4'b0000, 1'b1, 0, 7'h12, 1'b1};
        vecs[7]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'h40, 1'b1};
        vecs[8]  = '{16'h0000, 4'b0000, 1'b1, 1, 7'h7F, 1'b1};
        vecs[9]  = '{16'h0500, 4'b0000, 1'b1, 2, 7'h12, 1'b1};
        vecs[10] = '{16'h0500, 4'b0000, 1'b1, 1, 7'h40, 1'b1};
        vecs[11] = '{16'h0500, 4'b0000, 1'b0, 3, 7'h40, 1'b1};
        vecs[12] = '{16'h0005, 4'b1111, 1'b1, 2, 7'h7F, 1'b1};
        vecs[13] = '{16'h0005, 4'b1111, 1'b1, 0, 7'h12, 1'b0};

        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-slot while digit 1 is lit, then restart from slot 0.
        value = 16'h12AF;
        dp_in = 4'b0100;
        load  = 1'b1;
        tick("rst_pre");
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick("rst_pre");
        check("rst_pre/an_digit1", 32'(an), 32'hD);
        do_reset();
        tick("rst_post");
        check("rst_post/first_gap", 32'(an), 32'hF);
        tick("rst_post");
        check("rst_post/first_show", 32'(an), 32'hE);

        // Table vectors: one frame each, with a fixed-constant check on the chosen digit.
        foreach (vecs[v]) begin
            do_reset();
            value      = vecs[v].value;
            dp_in      = vecs[v].dp;
            lz_en      = vecs[v].lz;
            blink_mask = 4'b0000;
            load       = 1'b1;
            tick("vec");
            load = 1'b0;
            for (int e = 2; e <= 16; e++) begin
                tick("vec");
                if (e == vecs[v].digit * SD + 3) begin
                    check($sformatf("vec%0d/seg", v), 32'(seg), 32'(vecs[v].seg));
                    check($sformatf("vec%0d/dp_n", v), 32'(dp_n), 32'(vecs[v].dp_n));
                end
            end
        end

        // Blink: digit 0 on for two frames, off for two, digit 1 steady.
        do_reset();
        lz_en      = 1'b0;
        dp_in      = 4'b0000;
        blink_mask = 4'b0001;
        value      = 16'h1111;
        load       = 1'b1;
        tick("blink");
        load = 1'b0;
        for (int e = 2; e <= 100; e++) begin
            tick("blink");
            case (e)
                3, 19, 67: check("blink/on", 32'(seg), 32'h79);
                35, 51:    check("blink/off", 32'(seg), 32'h7F);
                39:        check("blink/steady_digit1", 32'(seg), 32'h79);
                default: ;
            endcase
        end

        // Mid-slot load takes effect on the very next edge without a gap.
        do_reset();
        blink_mask = 4'b0000;
        value      = 16'h0009;
        load       = 1'b1;
        tick("midload");
        load = 1'b0;
        tick("midload");
        check("midload/old", 32'(seg), 32'h10);
        value = 16'h0003;
        load  = 1'b1;
        tick("midload");
        check("midload/same_edge", 32'(seg), 32'h10);
        load = 1'b0;
        tick("midload");
        check("midload/new", 32'(seg), 32'h30);
        check("midload/no_gap", 32'(an), 32'hE);

        // Random traffic against the reference, plus frame_tick spacing.
        do_reset();
        last_ft = 0;
        n_ft    = 0;
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
            tick("rand");
            if (frame_tick) begin
                n_ft++;
                check("frame_tick/period", 32'(p - last_ft), 32'd16);
                check("frame_tick/an", 32'(an), 32'h7);
                last_ft = p;
            end
        end
        load = 1'b0;
        check("frame_tick/count", 32'(n_ft), 32'd25);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
